rx_ctrl_timer: RTL and testbench
================================

// Module: rx_ctrl_timer
// PURPOSE
//  Receive control unit and bit timer for the UART receiver. Sits directly upstream of sr_9bit.
//  Detects the start bit on the raw serial line and times each bit period.
//  Drives sr_9bit's shift_enable (one strobe per bit, 8 data + 1 stop), then checks stop_bit.
//  Flags a good frame (load_buffer) or a framing error to the downstream data buffer.
// PARAMETERS
//  CLKS_PER_BIT  10  clocks per serial bit; even, >= 4
//  DATA_BITS     8   data bits per frame; strobe count per frame = DATA_BITS+1
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  n_rst          in   1  asynchronous active-low reset
//  serial_in      in   1  raw asynchronous serial line, idle high
//  stop_bit       in   1  stop-bit output of sr_9bit (MSB of shifted frame)
//  shift_strobe   out  1  1-cycle pulse to sr_9bit shift_enable, once per bit
//  load_buffer    out  1  1-cycle pulse: frame valid, packet_data stable this cycle
//  framing_error  out  1  sticky: last frame had stop_bit==0
//  rx_busy        out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, sync FFs and edge reg = 1 (idle line).
//  Input sync: serial_in -> 2-FF synchronizer -> s_in. Edge reg holds previous s_in.
//  Start detect: in IDLE, edge reg==1 and s_in==0 -> START_CHK, timer cleared.
//  States and transitions:
//   IDLE      -> START_CHK on start detect; framing_error cleared same edge.
//   START_CHK -> counts CLKS_PER_BIT/2 clocks (mid start bit), then samples s_in.
//                s_in==0 -> RECEIVE, timer cleared. s_in==1 -> IDLE (glitch reject, no strobe).
//   RECEIVE   -> timer counts 0..CLKS_PER_BIT-1. At terminal count: shift_strobe=1 for 1 cycle,
//                bit_cnt++, timer wraps to 0. On the (DATA_BITS+1)th strobe -> STOP_CHK.
//   STOP_CHK  -> one cycle so sr_9bit's registered stop_bit is valid.
//                stop_bit==1: load_buffer=1 this cycle. stop_bit==0: framing_error<=1.
//                Either way -> IDLE next edge.
//  Timing (CLKS_PER_BIT=10): 1st strobe 15 clocks after START_CHK entry.
//   Later strobes every 10 clocks. STOP_CHK 1 clock after 9th strobe.
//  Outputs are registered (Moore), no combinational path from inputs.
//  Boundary conditions:
//   - New falling edge during START_CHK, RECEIVE or STOP_CHK is ignored.
//   - Frame N+1 start edge in the same cycle as STOP_CHK -> missed.
//     Earliest accepted edge is one cycle after return to IDLE.
//   - serial_in held low forever after a frame: no new frame until a 1->0 edge.
//   - n_rst asserted mid-frame: immediate return to reset state.
//     No strobe or load_buffer pulse is emitted.
//   - bit_cnt width $clog2(DATA_BITS+2). Timer width $clog2(CLKS_PER_BIT). No overflow possible.
// CONFIGURATION
//  RX_CTRL_START_CHK_EN defined: START_CHK mid-bit recheck active, as described above.
//  Not defined: START_CHK still waits CLKS_PER_BIT/2 but always goes to RECEIVE
//   (no glitch rejection). Strobe timing is identical in both builds.
// STRUCTURE
//  rx_pkg: typedef enum logic [1:0] {IDLE, START_CHK, RECEIVE, STOP_CHK} rx_state_t;
//   localparams for CLKS_PER_BIT and DATA_BITS defaults.
//  Sub-module rx_bit_timer:
//   - clear/enable inputs; half_tc and bit_tc outputs.
//   - Internal bit counter; bits_done output.
//   - Instantiated once; the FSM stays in rx_ctrl_timer.
// TESTING  (CLKS_PER_BIT=10, sr_9bit instantiated downstream, bits LSB first)
//  1 Reset: n_rst=0 with serial_in=0 toggling -> all outputs 0.
//    No strobe within 5 clocks after release.
//  2 Frame 0xA5, stop=1 -> 9 strobes, 10 clocks apart, 1st 15 clocks after start check.
//    load_buffer pulses once; sr packet_data==8'hA5; framing_error=0.
//  3 Frame 0x3C, stop=0 -> 9 strobes, no load_buffer, framing_error=1.
//    framing_error stays 1 until the next start edge, then clears.
//  4 Low glitch of 3 clocks on idle line (macro defined) -> back to IDLE, 0 strobes, rx_busy<=1 only ~7 clocks.
//    Macro undefined: same stimulus yields 9 strobes.
//  5 Back-to-back frames 0x00 then 0xFF, 0 idle gap after stop bit.
//    -> two load_buffer pulses; packet_data 8'h00 then 8'hFF.
//  6 n_rst pulsed after 4th strobe -> no further strobes, no load_buffer.
//    Next full frame 0x5A received correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and default sizing for the UART receive control path.
package rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 10;
  localparam int unsigned DATA_BITS_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE,
    START_CHK,
    RECEIVE,
    STOP_CHK
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer plus bit counter for the UART receiver.
// half_tc_o marks mid start bit, bit_tc_o marks the end of each bit period.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic half_tc_o,
  output logic bit_tc_o,
  output logic bits_done_o
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CntW   = $clog2(DATA_BITS + 2);

  localparam logic [TimerW-1:0] HalfLast = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]   BitsAll  = CntW'(DATA_BITS + 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;

  assign half_tc_o   = enable_i && (timer_q == HalfLast);
  assign bit_tc_o    = enable_i && (timer_q == BitLast);
  assign bits_done_o = (bit_cnt_q == BitsAll);

  always_comb begin
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    if (clear_i) begin
      timer_d   = '0;
      bit_cnt_d = '0;
    end else if (enable_i) begin
      if (timer_q == BitLast) begin
        timer_d   = '0;
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/rx_ctrl_timer.sv
// UART receive control FSM: start detect, per-bit shift strobes, stop-bit check.
// Define RX_CTRL_START_CHK_EN to reject start bits that are high again at mid-bit.
module rx_ctrl_timer
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  rx_state_t state_q, state_d;

  logic sync1_q, sync1_d;
  logic s_in_q, s_in_d;
  logic edge_q, edge_d;
  logic strobe_q, strobe_d;
  logic load_q, load_d;
  logic ferr_q, ferr_d;
  logic busy_q, busy_d;

  logic timer_clear, timer_en;
  logic half_tc, bit_tc, bits_done;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_bit_timer (
    .clk_i      (clk),
    .rst_ni     (n_rst),
    .clear_i    (timer_clear),
    .enable_i   (timer_en),
    .half_tc_o  (half_tc),
    .bit_tc_o   (bit_tc),
    .bits_done_o(bits_done)
  );

  always_comb begin
    sync1_d     = serial_in;
    s_in_d      = sync1_q;
    edge_d      = s_in_q;
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    strobe_d    = 1'b0;
    load_d      = 1'b0;
    ferr_d      = ferr_q;

    unique case (state_q)
      IDLE: begin
        if (edge_q && !s_in_q) begin
          state_d     = START_CHK;
          timer_clear = 1'b1;
          ferr_d      = 1'b0;
        end
      end
      START_CHK: begin
        timer_en = 1'b1;
        if (half_tc) begin
          timer_clear = 1'b1;
`ifdef RX_CTRL_START_CHK_EN
          state_d = s_in_q ? IDLE : RECEIVE;
`else
          state_d = RECEIVE;
`endif
        end
      end
      RECEIVE: begin
        // Leave one cycle after the last strobe so the shifter has taken the stop bit.
        if (bits_done) begin
          state_d = STOP_CHK;
        end else begin
          timer_en = 1'b1;
          strobe_d = bit_tc;
        end
      end
      STOP_CHK: begin
        state_d = IDLE;
        if (stop_bit) begin
          load_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b1;
      s_in_q   <= 1'b1;
      edge_q   <= 1'b1;
      strobe_q <= 1'b0;
      load_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      s_in_q   <= s_in_d;
      edge_q   <= edge_d;
      strobe_q <= strobe_d;
      load_q   <= load_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign shift_strobe  = strobe_q;
  assign load_buffer   = load_q;
  assign framing_error = ferr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_rx_ctrl_timer.sv
// Scoreboard bench for rx_ctrl_timer with a behavioural 9-bit receive shifter downstream.
module tb_rx_ctrl_timer;

  logic clk = 1'b0;
  logic n_rst;
  logic serial_in;
  logic stop_bit;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  always #5 clk = ~clk;

  rx_ctrl_timer #(
    .CLKS_PER_BIT(10),
    .DATA_BITS   (8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .stop_bit     (stop_bit),
    .shift_strobe (shift_strobe),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  // Downstream shifter, LSB first: after 9 shifts sr[7:0] is data, sr[8] the stop bit.
  logic [8:0] sr;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr <= '0;
    else if (shift_strobe) sr <= {serial_in, sr[8:1]};
  end
  assign stop_bit = sr[8];

  typedef enum int {EvLoad, EvFerr} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_ev;
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  total_strobes = 0;
  int  frame_strobes = 0;
  int  busy_start = 0;
  int  last_strobe = 0;
  logic busy_prev = 1'b0;
  logic ferr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t ev;
    ev.kind = k;
    ev.data = d;
    exp_q.push_back(ev);
  endtask

  // Monitor: strobe timing against rx_busy rise, and scoreboard pops on frame results.
  always @(negedge clk) begin
    if (!n_rst) begin
      busy_prev     = 1'b0;
      ferr_prev     = 1'b0;
      frame_strobes = 0;
    end else begin
      if (rx_busy && !busy_prev) begin
        busy_start    = cyc;
        frame_strobes = 0;
      end
      if (shift_strobe) begin
        frame_strobes++;
        total_strobes++;
        if (frame_strobes == 1)
          check(cyc - busy_start == 15, "first_strobe_delay", cyc - busy_start, 15);
        else
          check(cyc - last_strobe == 10, "strobe_gap", cyc - last_strobe, 10);
        last_strobe = cyc;
      end
      if (load_buffer) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_load", 1, 0);
        end else begin
          got_ev = exp_q.pop_front();
          check(got_ev.kind == EvLoad, "event_kind_load", int'(EvLoad), int'(got_ev.kind));
          check(sr[7:0] == got_ev.data, "packet_data", int'(sr[7:0]), int'(got_ev.data));
        end
      end
      if (framing_error && !ferr_prev) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_framing_error", 1, 0);
        end else begin
          got_ev = exp_q.pop_front();
          check(got_ev.kind == EvFerr, "event_kind_ferr", int'(EvFerr), int'(got_ev.kind));
        end
      end
      busy_prev = rx_busy;
      ferr_prev = framing_error;
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 serial_in = b;
    repeat (9) @(posedge clk);
  endtask

  // Start bit; the receiver sees the edge through two sync stages plus the edge register.
  task automatic send_start();
    @(posedge clk);
    #1 serial_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(rx_busy == 1'b1, "busy_on_start", int'(rx_busy), 1);
    check(framing_error == 1'b0, "ferr_cleared_on_start", int'(framing_error), 0);
    repeat (6) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    if (stop) push_ev(EvLoad, d);
    else push_ev(EvFerr, 8'h00);
    send_start();
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 serial_in = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  int s0;
  int busy_cnt;

  initial begin
    n_rst     = 1'b0;
    serial_in = 1'b0;

    // 1: reset with a toggling line
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 serial_in = ~serial_in;
    end
    @(negedge clk);
    check({shift_strobe, load_buffer, framing_error, rx_busy} == 4'b0000, "reset_outputs",
          int'({shift_strobe, load_buffer, framing_error, rx_busy}), 0);
    serial_in = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    s0 = total_strobes;
    repeat (5) @(negedge clk);
    check(total_strobes == s0, "no_strobe_after_release", total_strobes - s0, 0);
    check(rx_busy == 1'b0, "idle_after_release", int'(rx_busy), 0);

    // 2: good frame
    s0 = total_strobes;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check(total_strobes - s0 == 9, "strobes_a5", total_strobes - s0, 9);
    check(exp_q.size() == 0, "sb_drain_a5", exp_q.size(), 0);
    check(framing_error == 1'b0, "no_ferr_a5", int'(framing_error), 0);

    // 3: bad stop bit, sticky error
    s0 = total_strobes;
    send_frame(8'h3C, 1'b0);
    idle(20);
    check(total_strobes - s0 == 9, "strobes_3c", total_strobes - s0, 9);
    check(exp_q.size() == 0, "sb_drain_3c", exp_q.size(), 0);
    idle(30);
    check(framing_error == 1'b1, "ferr_sticky", int'(framing_error), 1);

    // 4: 3-clock low glitch on the idle line
    s0 = total_strobes;
`ifndef RX_CTRL_START_CHK_EN
    push_ev(EvLoad, 8'hFF);
`endif
    @(posedge clk);
    #1 serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 serial_in = 1'b1;
    busy_cnt = 0;
    repeat (130) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
`ifdef RX_CTRL_START_CHK_EN
    check(total_strobes - s0 == 0, "glitch_strobes", total_strobes - s0, 0);
    check(busy_cnt >= 1 && busy_cnt <= 7, "glitch_busy_len", busy_cnt, 7);
`else
    check(total_strobes - s0 == 9, "glitch_strobes", total_strobes - s0, 9);
`endif
    check(exp_q.size() == 0, "sb_drain_glitch", exp_q.size(), 0);
    check(framing_error == 1'b0, "ferr_cleared_by_glitch_start", int'(framing_error), 0);

    // 5: back-to-back frames with no idle gap
    s0 = total_strobes;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check(total_strobes - s0 == 18, "strobes_b2b", total_strobes - s0, 18);
    check(exp_q.size() == 0, "sb_drain_b2b", exp_q.size(), 0);

    // 6: reset after the 4th strobe, then a clean frame
    s0 = total_strobes;
    send_start();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    @(negedge clk);
    check(total_strobes - s0 == 4, "strobes_before_reset", total_strobes - s0, 4);
    n_rst     = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
    check({shift_strobe, load_buffer, framing_error, rx_busy} == 4'b0000, "midframe_reset_outputs",
          int'({shift_strobe, load_buffer, framing_error, rx_busy}), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    s0 = total_strobes;
    idle(120);
    check(total_strobes == s0, "no_strobe_after_reset", total_strobes - s0, 0);
    check(exp_q.size() == 0, "sb_no_load_after_reset", exp_q.size(), 0);
    s0 = total_strobes;
    send_frame(8'h5A, 1'b1);
    idle(20);
    check(total_strobes - s0 == 9, "strobes_5a", total_strobes - s0, 9);
    check(exp_q.size() == 0, "sb_drain_5a", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
